// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch front end with single-outstanding request and fetch FIFO
//
// Owns the fetch PC, issues one request at a time on the instruction-memory
// valid/ready bus, buffers {pc, instr} pairs in a DEPTH-entry FIFO and presents
// the head to the ID stage. A redirect from EX flushes the FIFO, retargets the
// fetch PC and drops any response still in flight for the old path.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   redirect_i          taken jump/branch resolved in EX this cycle
//   redirect_pc_i       redirect target (low two bits ignored)
//   imem_req_valid_o    fetch request valid (registered)
//   imem_req_ready_i    memory accepts the request
//   imem_req_addr_o     fetch address, word aligned
//   imem_rsp_valid_i    in-order instruction return, one per accepted request
//   imem_rsp_data_i     returned instruction
//   id_valid_o          FIFO head valid toward ID
//   id_ready_i          ID accepts the head this cycle
//   id_pc_o             PC of the head entry
//   id_instr_o          instruction of the head entry

module if_prefetch_unit #(
  parameter int              XLEN   = 64,
  parameter int              ILEN   = 32,
  parameter int              DEPTH  = 4,
  parameter logic [XLEN-1:0] RST_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [ILEN-1:0] id_instr_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            req_valid;

  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];

  logic            req_fire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_tgt;
  logic            unused_pc_bits;

  assign redirect_tgt   = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign req_fire = req_valid & imem_req_ready_i;
  // A redirect suppresses both the push of a returning response and any pop.
  assign push     = (state == S_WAIT) & imem_rsp_valid_i & ~redirect_i;
  assign pop      = (count != '0) & id_ready_i & ~redirect_i;

  always_comb begin
    count_nxt = count;
    if (redirect_i) begin
      count_nxt = '0;
    end else if (push & ~pop) begin
      count_nxt = count + 1'b1;
    end else if (pop & ~push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Request FSM. req_valid is registered and computed from the occupancy the
  // FIFO will have after this edge, so a request only issues with a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      fetch_pc  <= RST_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc    <= fetch_pc;
            req_valid <= 1'b0;
            // The old-path request already left; its response must be dropped.
            state     <= redirect_i ? S_DROP : S_WAIT;
            fetch_pc  <= redirect_i ? redirect_tgt : fetch_pc + XLEN'(4);
          end else begin
            // Address is held while valid is pending unless redirected.
            req_valid <= (count_nxt < DEPTH_C);
            if (redirect_i) begin
              fetch_pc <= redirect_tgt;
            end
          end
        end
        S_WAIT: begin
          if (redirect_i) begin
            fetch_pc <= redirect_tgt;
          end
          if (imem_rsp_valid_i) begin
            state     <= S_REQ;
            req_valid <= (count_nxt < DEPTH_C);
          end else if (redirect_i) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (redirect_i) begin
            fetch_pc <= redirect_tgt;
          end
          if (imem_rsp_valid_i) begin
            state     <= S_REQ;
            req_valid <= (count_nxt < DEPTH_C);
          end
        end
        default: begin
          state     <= S_REQ;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Fetch FIFO: no bypass, head read straight from storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      if (redirect_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= req_pc;
          instr_mem[wr_ptr] <= imem_rsp_data_i;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc;
  assign id_valid_o       = (count != '0);
  assign id_pc_o          = pc_mem[rd_ptr];
  assign id_instr_o       = instr_mem[rd_ptr];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - self-checking bench for if_prefetch_unit

module tb_if_prefetch_unit;

  localparam int              XLEN   = 64;
  localparam int              ILEN   = 32;
  localparam int              DEPTH  = 4;
  localparam logic [XLEN-1:0] RST_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid_o;
  logic            req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            rsp_valid = 1'b0;
  logic [ILEN-1:0] rsp_data = '0;
  logic            id_valid_o;
  logic            id_ready = 1'b0;
  logic [XLEN-1:0] id_pc_o;
  logic [ILEN-1:0] id_instr_o;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RST_PC(RST_PC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } exp_t;

  typedef struct {
    logic [XLEN-1:0] target;
    int              lat;
    int              id_pct;
    int              req_pct;
    int              n;
    logic [XLEN-1:0] exp_first;
  } vec_t;

  exp_t            sbq[$];
  logic [XLEN-1:0] pop_log[$];
  vec_t            vecs[4];

  int              checks = 0;
  int              errors = 0;

  logic [XLEN-1:0] exp_addr;
  logic            outstanding;
  logic            drop_pend;
  logic [XLEN-1:0] pend_pc;
  int              mem_cnt;
  int              mem_lat = 1;
  int              accepts;
  int              pops = 0;
  bit              got_first;
  logic [XLEN-1:0] first_pop_pc;
  bit              last_fire;
  logic [XLEN-1:0] last_fire_addr;

  function automatic logic [ILEN-1:0] instr_of(logic [XLEN-1:0] pc);
    return pc[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle. Entered just after a falling edge: DUT outputs are stable
  // for the cycle, inputs are chosen, the model is advanced to what the next
  // rising edge must produce, then the task waits for the next falling edge.
  task automatic step();
    bit   fire;
    bit   do_pop;
    exp_t e;
    check("id_valid", id_valid_o, (sbq.size() != 0));
    rsp_valid = 1'b0;
    if (outstanding) begin
      if (mem_cnt <= 1) begin
        rsp_valid = 1'b1;
        rsp_data  = instr_of(pend_pc);
      end else begin
        mem_cnt--;
      end
    end
    fire   = imem_req_valid_o && req_ready;
    do_pop = id_valid_o && id_ready && !redirect;
    if (do_pop) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: id_pc %h popped with nothing expected", id_pc_o);
      end else begin
        e = sbq.pop_front();
        check("id_pc", id_pc_o, e.pc);
        check("id_instr", XLEN'(id_instr_o), XLEN'(e.instr));
        pops++;
        pop_log.push_back(id_pc_o);
        if (!got_first) begin
          got_first    = 1'b1;
          first_pop_pc = id_pc_o;
        end
      end
    end
    if (rsp_valid) begin
      if (!drop_pend && !redirect) sbq.push_back('{pend_pc, instr_of(pend_pc)});
      outstanding = 1'b0;
    end
    if (fire) begin
      check("single_outstanding", XLEN'(outstanding), '0);
      check("req_addr", imem_req_addr_o, exp_addr);
      pend_pc        = imem_req_addr_o;
      outstanding    = 1'b1;
      mem_cnt        = mem_lat;
      drop_pend      = redirect;
      accepts++;
      exp_addr       = exp_addr + 64'd4;
      last_fire_addr = imem_req_addr_o;
    end
    last_fire = fire;
    if (redirect) begin
      sbq.delete();
      if (outstanding) drop_pend = 1'b1;
      exp_addr = {redirect_pc[XLEN-1:2], 2'b00};
    end
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    redirect  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    id_ready  = 1'b0;
    #1;
    check("rst_req_valid", XLEN'(imem_req_valid_o), '0);
    check("rst_id_valid", XLEN'(id_valid_o), '0);
    check("rst_id_pc", id_pc_o, '0);
    check("rst_id_instr", XLEN'(id_instr_o), '0);
    check("rst_addr", imem_req_addr_o, RST_PC);
    sbq.delete();
    pop_log.delete();
    exp_addr    = RST_PC;
    outstanding = 1'b0;
    drop_pend   = 1'b0;
    accepts     = 0;
    got_first   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fire(int budget);
    int cyc = 0;
    last_fire = 1'b0;
    while (!last_fire && cyc < budget) begin
      step();
      cyc++;
    end
    checks++;
    if (!last_fire) begin
      errors++;
      $display("FAIL wait_fire: no request accepted within %0d cycles", budget);
    end
  endtask

  task automatic run_pops(int n, int budget, bit rnd, int id_pct, int req_pct);
    int target = pops + n;
    int cyc = 0;
    while (pops < target && cyc < budget) begin
      if (rnd) begin
        id_ready  = ($urandom_range(99) < id_pct);
        req_ready = ($urandom_range(99) < req_pct);
      end
      step();
      cyc++;
    end
    checks++;
    if (pops < target) begin
      errors++;
      $display("FAIL run_pops: popped %0d of %0d within %0d cycles", pops - (target - n), n, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int a0;
    vecs[0] = '{64'h0000_0000_0000_1000, 1, 100, 100, 6, 64'h0000_0000_0000_1000};
    vecs[1] = '{64'h0000_0000_0000_2003, 2, 50, 70, 8, 64'h0000_0000_0000_2000};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF6, 1, 30, 100, 5, 64'hFFFF_FFFF_FFFF_FFF4};
    vecs[3] = '{64'h1234_5678_9ABC_DEF1, 4, 80, 40, 6, 64'h1234_5678_9ABC_DEF0};

    #2;
    // Sequential fetch, 1-cycle memory, ID always ready.
    do_reset();
    mem_lat = 1; req_ready = 1'b1; id_ready = 1'b1;
    wait_fire(10);
    check("t1_first_addr", last_fire_addr, 64'h8000_0000);
    step();
    check("t1_min_latency", XLEN'(id_valid_o), 64'd1);
    check("t1_head_pc", id_pc_o, 64'h8000_0000);
    run_pops(3, 20, 1'b0, 0, 0);
    if (pop_log.size() >= 3) begin
      check("t1_pop0", pop_log[0], 64'h8000_0000);
      check("t1_pop1", pop_log[1], 64'h8000_0004);
      check("t1_pop2", pop_log[2], 64'h8000_0008);
    end else begin
      checks++; errors++;
      $display("FAIL t1_pop_log: got %0d pops expected 3", pop_log.size());
    end
    wait_fire(10);
    a0 = accepts;
    repeat (20) step();
    check("t1_throughput", XLEN'(accepts - a0), 64'd10);

    // FIFO fills with ID stalled, then drains.
    do_reset();
    mem_lat = 1; req_ready = 1'b1; id_ready = 1'b0;
    repeat (20) step();
    check("t2_accepts", XLEN'(accepts), 64'd4);
    check("t2_req_valid_held", XLEN'(imem_req_valid_o), '0);
    id_ready = 1'b1;
    wait_fire(10);
    check("t2_next_addr", last_fire_addr, 64'h8000_0010);
    check("t2_first_pop", first_pop_pc, 64'h8000_0000);

    // Redirect while waiting; response three cycles after accept is dropped.
    do_reset();
    mem_lat = 3; req_ready = 1'b1; id_ready = 1'b1;
    wait_fire(10);
    redirect = 1'b1; redirect_pc = 64'h8000_1002;
    got_first = 1'b0;
    step();
    wait_fire(20);
    check("t3_redirect_addr", last_fire_addr, 64'h8000_1000);
    run_pops(1, 30, 1'b0, 0, 0);
    check("t3_first_pop", first_pop_pc, 64'h8000_1000);

    // Redirect in the same cycle as the response.
    do_reset();
    mem_lat = 1; req_ready = 1'b1; id_ready = 1'b1;
    wait_fire(10);
    redirect = 1'b1; redirect_pc = 64'h8000_2000;
    step();
    check("t4_id_valid", XLEN'(id_valid_o), '0);
    check("t4_req_valid", XLEN'(imem_req_valid_o), 64'd1);
    check("t4_addr", imem_req_addr_o, 64'h8000_2000);

    // Redirect in S_REQ with memory not ready and three entries buffered.
    do_reset();
    mem_lat = 1; req_ready = 1'b1; id_ready = 1'b0;
    cyc = 0;
    while (sbq.size() < 3 && cyc < 50) begin step(); cyc++; end
    check("t5_filled", XLEN'(sbq.size()), 64'd3);
    req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_3000;
    step();
    check("t5_req_valid", XLEN'(imem_req_valid_o), 64'd1);
    check("t5_addr", imem_req_addr_o, 64'h8000_3000);
    check("t5_flushed", XLEN'(id_valid_o), '0);
    got_first = 1'b0;
    req_ready = 1'b1; id_ready = 1'b1;
    run_pops(2, 30, 1'b0, 0, 0);
    check("t5_first_pop", first_pop_pc, 64'h8000_3000);

    // Reset mid-operation in S_WAIT with two entries buffered.
    do_reset();
    mem_lat = 2; req_ready = 1'b1; id_ready = 1'b0;
    cyc = 0;
    while (!(sbq.size() == 2 && outstanding) && cyc < 50) begin step(); cyc++; end
    check("t6_setup", XLEN'(sbq.size()), 64'd2);
    do_reset();
    req_ready = 1'b1; id_ready = 1'b1;
    wait_fire(10);
    check("t6_addr_after_reset", last_fire_addr, 64'h8000_0000);

    // Table: redirect at an arbitrary point, then random backpressure.
    for (int v = 0; v < 4; v++) begin
      mem_lat     = vecs[v].lat;
      redirect    = 1'b1;
      redirect_pc = vecs[v].target;
      got_first   = 1'b0;
      step();
      run_pops(vecs[v].n, 400, 1'b1, vecs[v].id_pct, vecs[v].req_pct);
      check($sformatf("vec%0d_first_pop", v), first_pop_pc, vecs[v].exp_first);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
